// File: rtl/sram_arb.sv
// Video/CPU arbiter for a shared 16-bit async SRAM; every access is ADR, SMP, then a strobe in IDLE.
// Define SRAM_ARB_FAIR_EN to cap consecutive video grants at VBURST while the CPU waits.
module sram_arb #(
    parameter int unsigned VBURST = 4
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        vreq,
    input  logic [17:0] vaddr,
    output logic [15:0] vdata,
    output logic        vstb,
    input  logic        creq,
    input  logic        cwe,
    input  logic [18:0] caddr,
    input  logic [7:0]  cdin,
    output logic [7:0]  cdout,
    output logic        cack,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_i,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [1:0] {StIdle, StAdr, StSmp} state_e;
    typedef enum logic {OwnVid, OwnCpu} owner_e;

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic        write_q, write_d;
    logic        lane_q, lane_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] dq_o_q, dq_o_d;
    logic        dq_oe_q, dq_oe_d;
    logic        we_n_q, we_n_d;
    logic        oe_n_q, oe_n_d;
    logic        ub_n_q, ub_n_d;
    logic        lb_n_q, lb_n_d;
    logic [15:0] vdata_q, vdata_d;
    logic        vstb_q, vstb_d;
    logic [7:0]  cdout_q, cdout_d;
    logic        cack_q, cack_d;

    logic vid_elig, cpu_elig, cpu_turn, grant_vid, grant_cpu;

    // A request seen during its own strobe cycle is the one just served.
    assign vid_elig = vreq & ~vstb_q;
    assign cpu_elig = creq & ~cack_q;

`ifdef SRAM_ARB_FAIR_EN
    localparam logic [2:0] VBurstCnt = 3'(VBURST);

    logic [2:0] burst_q, burst_d;

    assign cpu_turn = vid_elig & cpu_elig & (burst_q == VBurstCnt);

    always_comb begin
        burst_d = burst_q;
        if (grant_vid) begin
            burst_d = cpu_elig ? burst_q + 3'd1 : 3'd0;
        end else if (grant_cpu) begin
            burst_d = 3'd0;
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            burst_q <= 3'd0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    logic unused_vburst;
    assign unused_vburst = ^VBURST;
    assign cpu_turn      = 1'b0;
`endif

    assign grant_vid = (state_q == StIdle) & vid_elig & ~cpu_turn;
    assign grant_cpu = (state_q == StIdle) & cpu_elig & ~grant_vid;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        write_d = write_q;
        lane_d  = lane_q;
        addr_d  = addr_q;
        dq_o_d  = dq_o_q;
        dq_oe_d = dq_oe_q;
        we_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        vdata_d = vdata_q;
        vstb_d  = 1'b0;
        cdout_d = cdout_q;
        cack_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Write data was held through this cycle; release the bus unless a new write starts.
                dq_oe_d = 1'b0;
                if (grant_vid) begin
                    state_d = StAdr;
                    owner_d = OwnVid;
                    write_d = 1'b0;
                    addr_d  = vaddr;
                    oe_n_d  = 1'b0;
                    ub_n_d  = 1'b0;
                    lb_n_d  = 1'b0;
                end else if (grant_cpu) begin
                    state_d = StAdr;
                    owner_d = OwnCpu;
                    write_d = cwe;
                    lane_d  = caddr[0];
                    addr_d  = caddr[18:1];
                    if (cwe) begin
                        dq_o_d  = {cdin, cdin};
                        dq_oe_d = 1'b1;
                        ub_n_d  = ~caddr[0];
                        lb_n_d  = caddr[0];
                    end else begin
                        oe_n_d = 1'b0;
                        ub_n_d = 1'b0;
                        lb_n_d = 1'b0;
                    end
                end
            end
            StAdr: begin
                state_d = StSmp;
                we_n_d  = ~write_q;
                oe_n_d  = oe_n_q;
                ub_n_d  = ub_n_q;
                lb_n_d  = lb_n_q;
            end
            StSmp: begin
                state_d = StIdle;
                if (owner_q == OwnVid) begin
                    vstb_d  = 1'b1;
                    vdata_d = sram_dq_i;
                end else begin
                    cack_d = 1'b1;
                    if (!write_q) begin
                        cdout_d = lane_q ? sram_dq_i[15:8] : sram_dq_i[7:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= OwnVid;
            write_q <= 1'b0;
            lane_q  <= 1'b0;
            addr_q  <= 18'd0;
            dq_o_q  <= 16'd0;
            dq_oe_q <= 1'b0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            vdata_q <= 16'd0;
            vstb_q  <= 1'b0;
            cdout_q <= 8'd0;
            cack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            write_q <= write_d;
            lane_q  <= lane_d;
            addr_q  <= addr_d;
            dq_o_q  <= dq_o_d;
            dq_oe_q <= dq_oe_d;
            we_n_q  <= we_n_d;
            oe_n_q  <= oe_n_d;
            ub_n_q  <= ub_n_d;
            lb_n_q  <= lb_n_d;
            vdata_q <= vdata_d;
            vstb_q  <= vstb_d;
            cdout_q <= cdout_d;
            cack_q  <= cack_d;
        end
    end

    assign vdata      = vdata_q;
    assign vstb       = vstb_q;
    assign cdout      = cdout_q;
    assign cack       = cack_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_we_n  = we_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_ub_n  = ub_n_q;
    assign sram_lb_n  = lb_n_q;

endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: SRAM pin model, timeline-based reference model, directed and random traffic.
module tb_sram_arb;

    localparam int unsigned VBURST = 4;

    logic        mclk = 1'b0;
    logic        rst = 1'b0;
    logic        vreq, creq, cwe;
    logic [17:0] vaddr;
    logic [18:0] caddr;
    logic [7:0]  cdin, cdout;
    logic [15:0] vdata, sram_dq_o, sram_dq_i;
    logic        vstb, cack, sram_dq_oe, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
    logic [17:0] sram_addr;

    logic [15:0] sram_mem [262144];
    logic [15:0] ref_mem [262144];

    always #5 mclk = ~mclk;

    assign sram_dq_i = (sram_oe_n == 1'b0) ? sram_mem[sram_addr] : 16'hDEAD;

    sram_arb #(.VBURST(VBURST)) dut (
        .mclk(mclk), .rst(rst), .vreq(vreq), .vaddr(vaddr), .vdata(vdata), .vstb(vstb),
        .creq(creq), .cwe(cwe), .caddr(caddr), .cdin(cdin), .cdout(cdout), .cack(cack),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe),
        .sram_dq_i(sram_dq_i), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    // What each future cycle must look like, filled in when the model grants an access.
    typedef struct packed {
        logic        oe_n, we_n, ub_n, lb_n, dq_oe, vstb, cack, rd, wr, lane, set_addr, set_dq;
        logic [17:0] addr;
        logic [15:0] dq;
    } slot_t;

    slot_t       slots [8];
    int          vectors = 0;
    int          misc = 0;
    int          cyc = 0;
    int          free_at = 0;
`ifdef SRAM_ARB_FAIR_EN
    int          m_burst = 0;
`endif
    logic [17:0] exp_addr;
    logic [15:0] exp_dq, exp_vdata;
    logic [7:0]  exp_cdout;
    logic        obs_vstb, obs_cack, obs_oe_n, obs_we_n, obs_ub_n, obs_lb_n, obs_dq_oe;
    logic [17:0] obs_addr;
    logic [15:0] obs_vdata;
    logic [7:0]  obs_cdout;

    function automatic slot_t slot_idle();
        slot_t s;
        s = '0;
        s.oe_n = 1'b1;
        s.we_n = 1'b1;
        s.ub_n = 1'b1;
        s.lb_n = 1'b1;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s cyc=%0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) slots[i] = slot_idle();
        exp_addr  = '0;
        exp_dq    = '0;
        exp_vdata = '0;
        exp_cdout = '0;
        free_at   = 0;
`ifdef SRAM_ARB_FAIR_EN
        m_burst   = 0;
`endif
    endtask

    task automatic sched(input int c, input bit is_vid, input bit wr, input logic [17:0] a,
                         input logic lane, input logic [7:0] d);
        int i1 = (c + 1) % 8;
        int i2 = (c + 2) % 8;
        int i3 = (c + 3) % 8;
        slots[i1].set_addr = 1'b1;
        slots[i1].addr     = a;
        slots[i3].addr     = a;
        slots[i3].lane     = lane;
        slots[i3].vstb     = is_vid;
        slots[i3].cack     = !is_vid;
        if (wr) begin
            slots[i1].set_dq = 1'b1;
            slots[i1].dq     = {d, d};
            slots[i3].dq     = {d, d};
            slots[i3].wr     = 1'b1;
            for (int k = 1; k <= 3; k++) slots[(c + k) % 8].dq_oe = 1'b1;
            for (int k = 1; k <= 2; k++) begin
                slots[(c + k) % 8].ub_n = ~lane;
                slots[(c + k) % 8].lb_n = lane;
            end
            slots[i2].we_n = 1'b0;
        end else begin
            slots[i3].rd = !is_vid;
            for (int k = 1; k <= 2; k++) begin
                slots[(c + k) % 8].oe_n = 1'b0;
                slots[(c + k) % 8].ub_n = 1'b0;
                slots[(c + k) % 8].lb_n = 1'b0;
            end
        end
        free_at = c + 3;
    endtask

    task automatic cycle_eval();
        slot_t e;
        bit    v_el, c_el, to_vid;
        int    s;
        if (!sram_we_n) begin
            if (!sram_lb_n) sram_mem[sram_addr][7:0] = sram_dq_o[7:0];
            if (!sram_ub_n) sram_mem[sram_addr][15:8] = sram_dq_o[15:8];
        end
        if (rst) begin
            model_reset();
        end else begin
            s = cyc % 8;
            e = slots[s];
            if (e.set_addr) exp_addr = e.addr;
            if (e.set_dq) exp_dq = e.dq;
            if (e.vstb) exp_vdata = ref_mem[e.addr];
            if (e.cack && e.rd) exp_cdout = e.lane ? ref_mem[e.addr][15:8] : ref_mem[e.addr][7:0];
            if (e.cack && e.wr) begin
                if (e.lane) ref_mem[e.addr][15:8] = e.dq[15:8];
                else ref_mem[e.addr][7:0] = e.dq[7:0];
            end
            chk("vstb", vstb, e.vstb);
            chk("cack", cack, e.cack);
            chk("oe_n", sram_oe_n, e.oe_n);
            chk("we_n", sram_we_n, e.we_n);
            chk("ub_n", sram_ub_n, e.ub_n);
            chk("lb_n", sram_lb_n, e.lb_n);
            chk("dq_oe", sram_dq_oe, e.dq_oe);
            chk("sram_addr", sram_addr, exp_addr);
            chk("dq_o", sram_dq_o, exp_dq);
            chk("vdata", vdata, exp_vdata);
            chk("cdout", cdout, exp_cdout);
            if (cyc >= free_at) begin
                v_el   = vreq && !e.vstb;
                c_el   = creq && !e.cack;
                to_vid = v_el;
`ifdef SRAM_ARB_FAIR_EN
                if (v_el && c_el && m_burst == int'(VBURST)) to_vid = 1'b0;
                if (to_vid) m_burst = c_el ? m_burst + 1 : 0;
                else if (c_el) m_burst = 0;
`endif
                if (to_vid) sched(cyc, 1'b1, 1'b0, vaddr, 1'b0, 8'h00);
                else if (c_el) sched(cyc, 1'b0, cwe, caddr[18:1], caddr[0], cdin);
            end
            slots[s] = slot_idle();
        end
        obs_vstb  = vstb;
        obs_cack  = cack;
        obs_oe_n  = sram_oe_n;
        obs_we_n  = sram_we_n;
        obs_ub_n  = sram_ub_n;
        obs_lb_n  = sram_lb_n;
        obs_dq_oe = sram_dq_oe;
        obs_addr  = sram_addr;
        obs_vdata = vdata;
        obs_cdout = cdout;
        cyc++;
    endtask

    task automatic tick();
        @(negedge mclk);
        cycle_eval();
        @(posedge mclk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic new_cpu();
        creq  = 1'b1;
        cwe   = 1'($urandom_range(0, 1));
        caddr = {18'h100 | 18'($urandom_range(0, 63)), 1'($urandom_range(0, 1))};
        cdin  = 8'($urandom);
    endtask

    initial begin
        int          first_v, first_c, n_v, n_c;
        logic [15:0] saved;
        for (int i = 0; i < 262144; i++) begin
            sram_mem[i] = 16'(i) ^ 16'h5A5A;
            ref_mem[i]  = 16'(i) ^ 16'h5A5A;
        end
        sram_mem[18'h100] = 16'h1234;
        ref_mem[18'h100]  = 16'h1234;
        vreq = 0; creq = 0; cwe = 0; vaddr = '0; caddr = '0; cdin = '0;
        model_reset();

        #1 rst = 1'b1;
        #2;
        chk("rst_we_n", sram_we_n, 1'b1);
        chk("rst_oe_n", sram_oe_n, 1'b1);
        chk("rst_ub_lb", {sram_ub_n, sram_lb_n}, 2'b11);
        chk("rst_dq_oe", sram_dq_oe, 1'b0);
        chk("rst_strobes", {vstb, cack}, 2'b00);
        chk("rst_addr", sram_addr, 18'h0);
        @(posedge mclk);
        #1 rst = 1'b0;

        // Video read of the preloaded word.
        vreq = 1'b1; vaddr = 18'h100;
        tick(); chk("v_grant_oe", obs_oe_n, 1'b1);
        tick(); chk("v_adr_oe", obs_oe_n, 1'b0);
        tick(); chk("v_smp_oe", obs_oe_n, 1'b0);
        tick(); chk("v_vstb", obs_vstb, 1'b1); chk("v_vdata", obs_vdata, 16'h1234);
        vaddr = 18'h101;
        tick(); chk("v_no_early_adr", obs_oe_n, 1'b1);
        vreq = 1'b0;
        run(6);

        // CPU byte write to the high lane, then read both lanes back.
        creq = 1'b1; cwe = 1'b1; caddr = 19'h00201; cdin = 8'hA5;
        tick();
        tick(); chk("w_ub_n", obs_ub_n, 1'b0); chk("w_lb_n", obs_lb_n, 1'b1);
        chk("w_adr_we_n", obs_we_n, 1'b1); chk("w_addr", obs_addr, 18'h100);
        tick(); chk("w_smp_we_n", obs_we_n, 1'b0);
        tick(); chk("w_cack", obs_cack, 1'b1); chk("w_done_we_n", obs_we_n, 1'b1);
        cwe = 1'b0; caddr = 19'h00201;
        run(3);
        tick(); chk("r_hi_cack", obs_cack, 1'b1); chk("r_hi_cdout", obs_cdout, 8'hA5);
        caddr = 19'h00200;
        run(3);
        tick(); chk("r_lo_cack", obs_cack, 1'b1); chk("r_lo_cdout", obs_cdout, 8'h34);
        creq = 1'b0;
        run(4);

        // Both requests rise together: video first, CPU in the strobe cycle.
        vreq = 1'b1; vaddr = 18'h110; creq = 1'b1; cwe = 1'b0; caddr = 19'h00222;
        first_v = -1; first_c = -1; n_v = 0; n_c = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (obs_vstb) begin
                n_v++;
                if (first_v < 0) first_v = k;
                vaddr = vaddr + 18'd1;
            end
            if (obs_cack) begin
                n_c++;
                if (first_c < 0) first_c = k;
            end
        end
        chk("rise_vstb_at", 32'(first_v), 32'd3);
        chk("cack_after_vstb", 32'(first_c - first_v), 32'd3);
        chk("interleave_vstb_cnt", 32'(n_v), 32'd2);
        chk("interleave_cack_cnt", 32'(n_c), 32'd1);
        vreq = 1'b0; creq = 1'b0;
        run(6);

        // Reset asserted during the SMP cycle of a CPU write.
        saved = sram_mem[18'h201];
        creq = 1'b1; cwe = 1'b1; caddr = 19'h00402; cdin = 8'h5A;
        tick(); tick();
        chk("abort_pre_we_n", sram_we_n, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("abort_we_n", sram_we_n, 1'b1);
        chk("abort_dq_oe", sram_dq_oe, 1'b0);
        creq = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("abort_no_cack", obs_cack, 1'b0);
        end
        chk("abort_mem", sram_mem[18'h201], saved);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (obs_vstb) vaddr = 18'h100 | ((vaddr + 18'd1) & 18'h3F);
            if ($urandom_range(0, 9) == 0) vreq = ~vreq;
            if (!creq) begin
                if ($urandom_range(0, 3) == 0) new_cpu();
            end else if (obs_cack) begin
                if ($urandom_range(0, 1) == 1) new_cpu();
                else creq = 1'b0;
            end
        end
        vreq = 1'b0; creq = 1'b0;
        run(6);
        for (int w = 'h100; w < 'h140; w++) chk("mem_final", sram_mem[w], ref_mem[w]);
        chk("mem_final_201", sram_mem[18'h201], ref_mem[18'h201]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end

endmodule
